// File: rtl/serial_ones_comp_rx.sv
// serial_ones_comp_rx: bit-serial receiver that decodes a one's-complement serial frame into a parallel word
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   in_valid   - bit strobe; in_data sampled only when high
//   in_data    - serial line (complemented domain)
//   out_data   - recovered true word, held until the next frame completes
//   out_valid  - one-cycle pulse when out_data/parity_err update
//   parity_err - even-parity mismatch for out_data
//   busy       - frame in progress
module serial_ones_comp_rx #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             parity_err,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             parity_err_q, parity_err_d;
    logic [WIDTH-1:0] word_now;
    logic             last_bit;
    // Word including the bit being sampled this edge, so completion needs no extra cycle.
    always_comb begin
        word_now = shift_q;
        word_now[cnt_q] = ~in_data;
    end
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            parity_err_q <= parity_err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (in_valid && in_data) ? DATA : IDLE;
            DATA:    state_d = (in_valid && last_bit) ? (PARITY_EN ? PARITY : IDLE) : DATA;
            PARITY:  state_d = in_valid ? IDLE : PARITY;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        parity_err_d = parity_err_q;
        if (in_valid) begin
            case (state_q)
                IDLE: cnt_d = '0;
                DATA: begin
                    shift_d = word_now;
                    cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
                    if (last_bit && !PARITY_EN) begin
                        out_data_d   = word_now;
                        out_valid_d  = 1'b1;
                        parity_err_d = 1'b0;
                    end
                end
                PARITY: begin
                    out_data_d   = shift_q;
                    out_valid_d  = 1'b1;
                    // Wire carries the complement of the even-parity bit.
                    parity_err_d = (^shift_q) != ~in_data;
                end
                default: cnt_d = '0;
            endcase
        end
    end
    always_comb begin
        busy       = (state_q != IDLE);
        out_data   = out_data_q;
        out_valid  = out_valid_q;
        parity_err = parity_err_q;
    end
endmodule

// File: doc/serial_ones_comp_rx.md
Name: serial_ones_comp_rx

Overview:
- Bit-serial receiver and decoder for the one's-complement serial link: the far end of the serial complementer stream.
- Detects a start bit and shifts in WIDTH complemented data bits LSB-first.
- Re-complements them to recover the true word, checks an optional even-parity bit, and presents the word in parallel with a one-cycle valid strobe.
- Sits between the serial line and word-level consumer logic.

Parameters:
- WIDTH, 8, number of data bits per frame (>=2).
- PARITY_EN, 1, 1 = frame carries one parity bit after the data; 0 = no parity bit.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  bit strobe; in_data is sampled only on edges where in_valid=1.
- in_data  input  1  serial line, complemented domain.
- out_data  output  WIDTH  recovered true word; held until the next frame completes.
- out_valid  output  1  one-cycle pulse: out_data/parity_err updated.
- parity_err  output  1  parity mismatch for the word in out_data; held with out_data.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset: synchronous, active-high; clk and rst as named above. rst=1 at an edge forces state=IDLE, bit counter=0, shift register=0, out_data=0, out_valid=0, parity_err=0, busy=0. rst has priority over all other inputs.
- Wire format (sampled bits only): idle=0, start=1, then WIDTH wire bits LSB-first, then (if PARITY_EN) one parity wire bit.
  - Each data wire bit = ~true bit.
  - Parity wire bit = ~(XOR of true data bits), i.e. complement of the even-parity bit.
- FSM:
  - IDLE: on in_valid=1 && in_data=1 -> DATA, counter=0. in_data=0 stays in IDLE.
  - DATA: on each in_valid=1, shift in ~in_data at bit position counter, counter++. When the sampled bit is bit WIDTH-1 -> PARITY if PARITY_EN=1, else IDLE with word completion.
  - PARITY: on in_valid=1, compute err = (XOR of true data) != ~in_data; -> IDLE with word completion.
- Word completion, registered: on the edge sampling the final bit of the frame, out_data <= assembled word, parity_err <= err (0 when PARITY_EN=0), out_valid <= 1. out_valid is therefore high in the cycle after that edge, for exactly one cycle.
- Latency: out_valid is asserted 1 cycle after the final bit's sampling edge.
- in_valid=0 cycles: no state, counter or shift change (stall anywhere, including mid-frame and before parity).
- Back-to-back frames: the FSM returns to IDLE on the final-bit edge, so a start bit is accepted on the very next in_valid cycle. out_valid of frame N may coincide with the start-bit sampling of frame N+1.
- busy = 1 in DATA/PARITY, 0 in IDLE; combinational from state.
- Reset mid-frame: partial word discarded, no out_valid, outputs cleared.
- Counter width: $clog2(WIDTH); no wrap-around beyond WIDTH-1 is permitted.
- Between completions, out_data and parity_err hold their last values; they are never partially updated.

Test Plan:
- Decode 0xA5 with parity: with WIDTH=8, PARITY_EN=1, drive wire bits 1 | 0,1,0,1,1,0,1,0 | 1 with in_valid=1 every cycle -> exactly one out_valid pulse, 1 cycle after the parity edge, with out_data=0xA5, parity_err=0. busy=1 for 9 cycles.
- Parity error: same frame with the parity wire bit 0 -> out_data=0xA5, parity_err=1, one out_valid pulse.
- Stalls and back-to-back frames:
  - Stalls: same 0xA5 frame with in_valid low 2 cycles between every bit -> identical result, no extra or early pulse.
  - Back-to-back: frame 0x00 (data wire all 1, parity wire 1) immediately followed by 0xFF (data wire all 0, parity wire 1) -> two out_valid pulses with 0x00 then 0xFF, both parity_err=0, no idle cycle needed between frames.
- Reset mid-frame, then 0x3C: assert rst after the start bit plus 4 data bits, then send a full 0x3C frame (wire 1 | 1,1,0,0,0,0,1,1 | 1) -> only one out_valid with out_data=0x3C. out_data=0 immediately after reset.
- Idle line and PARITY_EN=0:
  - Idle line: in_valid=1, in_data=0 for 20 cycles -> busy=0, out_valid never asserted.
  - PARITY_EN=0: frame 1 | 0,1,0,1,1,0,1,0 -> out_valid 1 cycle after the 8th data bit, out_data=0xA5, parity_err=0.
